conv3x3_stream: RTL and testbench

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

---
 rtl/conv3x3_stream_if.sv | 29 ++
 rtl/conv3x3_stream.sv | 183 ++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_stream_if.sv
// Streaming handshake bundle for conv3x3_stream.
//   in_valid / in_ready / in_data        : pixel stream into the block
//   out_valid / out_ready / out_data /
//   out_last                             : result stream out of the block
// Modports:
//   master : stream source and result sink (testbench or upstream logic)
//   slave  : the convolution block itself
interface conv3x3_stream_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid (unpadded) convolution over IMG_H x IMG_W frames
// delivered in raster order.  One result per pixel with row>=2 and col>=2,
// three register stages from input transfer to out_valid.
// Ports:
//   clk     : sole clock, rising edge
//   reset   : synchronous, active-high
//   strm    : pixel-in / result-out handshake bundle (slave side)
//   w_load  : write one shadow coefficient this cycle
//   w_idx   : 0..8 weight[r][c] at 3r+c, 9 bias, 10..15 ignored
//   w_data  : coefficient value (weights use the low DATA_W bits)
//   relu_en : clamp negative sums to 0, latched at frame start
//   busy    : frame in progress or results still in flight
module conv3x3_stream #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                    clk,
  input  logic                    reset,
  conv3x3_stream_if.slave         strm,
  input  logic                    w_load,
  input  logic [3:0]              w_idx,
  input  logic signed [OUT_W-1:0] w_data,
  input  logic                    relu_en,
  output logic                    busy
);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + 4;
  // One guard bit above the wider of the sum and the output, so the
  // saturation compare never overflows itself.
  localparam int ACC_W  = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Handshake and position
  logic             advance, xfer, frame_start, qual, last_pix;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // The whole pipeline moves as one; a held result freezes every stage.
  assign advance       = !strm.out_valid || strm.out_ready;
  assign strm.in_ready = advance;
  assign xfer          = strm.in_valid && advance;
  assign frame_start   = xfer && (row == '0) && (col == '0);
  assign qual          = (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign last_pix      = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (xfer) begin
      if (col == COL_W'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Coefficients: shadow set written any time, active set copied only at
  // frame start so a frame is always computed with one coherent set.
  logic signed [DATA_W-1:0] w_shadow [9];
  logic signed [DATA_W-1:0] w_shadow_nxt [9];
  logic signed [DATA_W-1:0] w_act [9];
  logic signed [OUT_W-1:0]  b_shadow, b_shadow_nxt, b_act;
  logic                     relu_act;

  // The copy takes the post-write shadow values so a load coinciding with
  // the frame-start pixel is part of the new frame.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      w_shadow_nxt[k] = (w_load && (w_idx == 4'(k))) ? w_data[DATA_W-1:0] : w_shadow[k];
    end
    b_shadow_nxt = (w_load && (w_idx == 4'd9)) ? w_data : b_shadow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_shadow <= '{default: '0};
      w_act    <= '{default: '0};
      b_shadow <= '0;
      b_act    <= '0;
      relu_act <= 1'b0;
    end else begin
      w_shadow <= w_shadow_nxt;
      b_shadow <= b_shadow_nxt;
      if (frame_start) begin
        w_act    <= w_shadow_nxt;
        b_act    <= b_shadow_nxt;
        relu_act <= relu_en;
      end
    end
  end

  // Stage 1: line buffers and window.  lb1 holds row-2, lb0 row-1, both
  // addressed by column.  Window index 3r+c, r=0 oldest row, c=2 newest.
  logic signed [DATA_W-1:0] lb0 [IMG_W];
  logic signed [DATA_W-1:0] lb1 [IMG_W];
  logic signed [DATA_W-1:0] win [9];

  // NOTE: line buffers and window are pure datapath with no reset; only the
  // valid flags that qualify them are cleared, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (xfer) begin
      lb1[col] <= lb0[col];
      lb0[col] <= strm.in_data;
      for (int r = 0; r < 3; r++) begin
        win[3*r]     <= win[3*r + 1];
        win[3*r + 1] <= win[3*r + 2];
      end
      win[2] <= lb1[col];
      win[5] <= lb0[col];
      win[8] <= strm.in_data;
    end
  end

  // Stage 2: full-width products.  Bias and relu travel with the products
  // so the tail of one frame is not affected by the next frame's copy.
  logic signed [PROD_W-1:0] prod [9];
  logic signed [OUT_W-1:0]  bias2;
  logic                     relu2;
  logic                     v1, l1, v2, l2;

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < 9; k++) begin
        prod[k] <= PROD_W'(win[k]) * PROD_W'(w_act[k]);
      end
      bias2 <= b_act;
      relu2 <= relu_act;
    end
  end

  // Stage 3: sum, optional relu, saturate.
  logic signed [ACC_W-1:0] acc, clip, sat;

  always_comb begin
    // NOTE: blocking assignments accumulate in order within one evaluation,
    // and every variable is given a value first so no latch is inferred.
    acc = ACC_W'(bias2);
    for (int k = 0; k < 9; k++) begin
      acc = acc + ACC_W'(prod[k]);
    end
    clip = (relu2 && acc[ACC_W-1]) ? '0 : acc;
    if (clip > SAT_MAX)      sat = SAT_MAX;
    else if (clip < SAT_MIN) sat = SAT_MIN;
    else                     sat = clip;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1             <= 1'b0;
      l1             <= 1'b0;
      v2             <= 1'b0;
      l2             <= 1'b0;
      strm.out_valid <= 1'b0;
      strm.out_last  <= 1'b0;
      strm.out_data  <= '0;
    end else if (advance) begin
      v1             <= xfer && qual;
      l1             <= xfer && last_pix;
      v2             <= v1;
      l2             <= l1;
      strm.out_valid <= v2;
      strm.out_last  <= l2;
      if (v2) strm.out_data <= sat[OUT_W-1:0];
    end
  end

  // A new frame starting on the same edge as the previous out_last
  // transfer keeps busy high.
  always_ff @(posedge clk) begin
    if (reset)                                              busy <= 1'b0;
    else if (frame_start)                                   busy <= 1'b1;
    else if (strm.out_valid && strm.out_ready && strm.out_last) busy <= 1'b0;
  end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on 4x4 frames.  Two instances share all
// stimulus: dut_a (OUT_W=32) and dut_b (OUT_W=16, used for saturation).
module tb_conv3x3_stream;
  typedef logic signed [15:0] frame_t [16];
  typedef logic signed [31:0] coef_t [9];
  typedef longint             exp_t [4];

  logic               clk = 1'b0;
  logic               reset;
  logic               w_load;
  logic [3:0]         w_idx;
  logic signed [31:0] w_data;
  logic               relu_en;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_ready;
  logic               busy_a, busy_b;

  int n_cmp = 0;
  int n_mis = 0;

  logic signed [63:0] res_a[$];
  logic signed [63:0] res_b[$];
  logic               last_a[$];
  logic               last_b[$];
  int                 t_in11, t_out1, n_stall;
  logic               saw_busy;

  always #5 clk = ~clk;

  conv3x3_stream_if #(.DATA_W(16), .OUT_W(32)) ifa ();
  conv3x3_stream_if #(.DATA_W(16), .OUT_W(16)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.out_ready = out_ready;

  conv3x3_stream #(.DATA_W(16), .OUT_W(32), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .reset(reset), .strm(ifa), .w_load(w_load), .w_idx(w_idx),
    .w_data(w_data), .relu_en(relu_en), .busy(busy_a)
  );

  conv3x3_stream #(.DATA_W(16), .OUT_W(16), .IMG_W(4), .IMG_H(4)) dut_b (
    .clk(clk), .reset(reset), .strm(ifb), .w_load(w_load), .w_idx(w_idx),
    .w_data(w_data[15:0]), .relu_en(relu_en), .busy(busy_b)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic frame_t const_frame(input logic signed [15:0] v);
    frame_t f;
    for (int i = 0; i < 16; i++) f[i] = v;
    return f;
  endfunction

  // Pixel (r,c) = 4r+c+1
  function automatic frame_t ramp_frame();
    frame_t f;
    for (int i = 0; i < 16; i++) f[i] = 16'(i + 1);
    return f;
  endfunction

  function automatic coef_t const_coef(input logic signed [31:0] v);
    coef_t c;
    for (int k = 0; k < 9; k++) c[k] = v;
    return c;
  endfunction

  // Called in the region just after a rising edge.
  task automatic load_coefs(input coef_t c);
    for (int k = 0; k < 9; k++) begin
      w_load = 1'b1;
      w_idx  = 4'(k);
      w_data = c[k];
      @(posedge clk); #1;
    end
    w_load = 1'b0;
  endtask

  // Streams n_pix pixels, collects results, optionally holds out_ready low
  // for stall_len cycles once out_valid first appears, and optionally pulses
  // a bias load on loop cycle load_cyc.  Ends just after a rising edge.
  task automatic run_frame(input frame_t pix, input int n_pix, input int stall_len,
                           input int load_cyc, input logic signed [31:0] load_val);
    int                 idx = 0;
    int                 stall_left = stall_len;
    logic               stalled;
    logic               done = 1'b0;
    logic signed [63:0] held_d = 0;
    logic               held_l = 1'b0;
    res_a.delete(); res_b.delete(); last_a.delete(); last_b.delete();
    t_in11 = -1; t_out1 = -1; n_stall = 0; saw_busy = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      in_valid  = (idx < n_pix);
      in_data   = (idx < 16) ? pix[idx] : 16'sd0;
      w_load    = (cyc == load_cyc);
      w_idx     = 4'd9;
      w_data    = load_val;
      stalled   = (stall_left > 0) && ifa.out_valid;
      if (stalled) stall_left--;
      out_ready = !stalled;
      @(negedge clk);
      if (busy_a) saw_busy = 1'b1;
      if (stalled) begin
        check("stall in_ready", ifa.in_ready, 0);
        if (n_stall == 0) begin
          held_d = ifa.out_data;
          held_l = ifa.out_last;
        end else begin
          check("stall out_data", ifa.out_data, held_d);
          check("stall out_last", ifa.out_last, held_l);
        end
        n_stall++;
      end
      if (in_valid && ifa.in_ready) begin
        if (idx == 10) t_in11 = cyc;
        idx++;
      end
      if (ifa.out_valid && t_out1 < 0) t_out1 = cyc;
      if (ifa.out_valid && out_ready) begin
        res_a.push_back(ifa.out_data);
        last_a.push_back(ifa.out_last);
        res_b.push_back(ifb.out_data);
        last_b.push_back(ifb.out_last);
      end
      done = (n_pix < 16) ? (idx == n_pix) : (idx == 16 && !busy_a);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    w_load    = 1'b0;
    out_ready = 1'b1;
    if (!done) begin
      check("frame timeout pixels", idx, n_pix);
      check("frame timeout busy", busy_a, 0);
    end
  endtask

  task automatic check_a(input string tag, input exp_t e);
    check($sformatf("%s a count", tag), res_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s a data[%0d]", tag, i), (i < res_a.size()) ? res_a[i] : 64'bx, e[i]);
      check($sformatf("%s a last[%0d]", tag, i), (i < last_a.size()) ? last_a[i] : 1'bx, i == 3);
    end
  endtask

  task automatic check_b(input string tag, input exp_t e);
    check($sformatf("%s b count", tag), res_b.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s b data[%0d]", tag, i), (i < res_b.size()) ? res_b[i] : 64'bx, e[i]);
      check($sformatf("%s b last[%0d]", tag, i), (i < last_b.size()) ? last_b[i] : 1'bx, i == 3);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    coef_t c_ramp;
    for (int k = 0; k < 9; k++) c_ramp[k] = 32'(k + 1);

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    w_load = 1'b0; w_idx = '0; w_data = '0; relu_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset out_valid", ifa.out_valid, 0);
    check("reset out_last", ifa.out_last, 0);
    check("reset out_data", ifa.out_data, 0);
    check("reset busy", busy_a, 0);
    check("reset in_ready", ifa.in_ready, 1);
    check("reset b busy", busy_b, 0);
    check("reset b in_ready", ifb.in_ready, 1);
    @(posedge clk); #1;

    // All-ones frame, unit weights: 4 results of 9, latency 3
    load_coefs(const_coef(32'sd1));
    run_frame(const_frame(16'sd1), 16, 0, -1, 0);
    check_a("ones", '{9, 9, 9, 9});
    check("ones latency", t_out1 - t_in11, 3);
    check("ones busy seen", saw_busy, 1);

    // Positive saturation
    load_coefs(const_coef(32'sd32767));
    run_frame(const_frame(16'sd32767), 16, 0, -1, 0);
    check_b("sat pos", '{32767, 32767, 32767, 32767});
    check_a("sat pos", '{2147483647, 2147483647, 2147483647, 2147483647});

    // Negative saturation
    load_coefs(const_coef(-32'sd32768));
    run_frame(const_frame(16'sd32767), 16, 0, -1, 0);
    check_b("sat neg", '{-32768, -32768, -32768, -32768});
    check_a("sat neg", '{-64'sd2147483648, -64'sd2147483648, -64'sd2147483648, -64'sd2147483648});

    // Relu on/off with centre weight -1
    load_coefs('{0, 0, 0, 0, -1, 0, 0, 0, 0});
    relu_en = 1'b1;
    run_frame(const_frame(16'sd5), 16, 0, -1, 0);
    check_a("relu on", '{0, 0, 0, 0});
    relu_en = 1'b0;
    run_frame(const_frame(16'sd5), 16, 0, -1, 0);
    check_a("relu off", '{-5, -5, -5, -5});

    // Distinct weights on a ramp: 45*(4R+C+1) + 303 per window
    load_coefs(c_ramp);
    run_frame(ramp_frame(), 16, 0, -1, 0);
    check_a("ramp", '{348, 393, 528, 573});

    // Output stall of 5 cycles
    run_frame(ramp_frame(), 16, 5, -1, 0);
    check("stall cycles", n_stall, 5);
    check_a("stall", '{348, 393, 528, 573});

    // Bias loaded mid-frame applies from the next frame
    run_frame(ramp_frame(), 16, 0, 5, 32'sd100);
    check_a("bias mid", '{348, 393, 528, 573});
    run_frame(ramp_frame(), 16, 0, -1, 0);
    check_a("bias next", '{448, 493, 628, 673});

    // Reset mid-frame aborts and clears coefficients
    run_frame(ramp_frame(), 7, 0, -1, 0);
    check("pre-reset busy", busy_a, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort out_valid", ifa.out_valid, 0);
    check("abort busy", busy_a, 0);
    @(posedge clk); #1;
    load_coefs(c_ramp);
    run_frame(ramp_frame(), 16, 0, -1, 0);
    check_a("after abort", '{348, 393, 528, 573});

    // Bias load on the frame-start transfer is included
    run_frame(ramp_frame(), 16, 0, 0, -32'sd48);
    check_a("bias start", '{300, 345, 480, 525});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
